// File: rtl/cu_pkg.sv
// Shared encodings for the microsequencer, bus mux and datapath:
// bus source codes, opcodes, ALU ops and FSM state encoding.
package cu_pkg;

  localparam logic [3:0] BUS_AR   = 4'd0;
  localparam logic [3:0] BUS_PC   = 4'd1;
  localparam logic [3:0] BUS_IR   = 4'd2;
  localparam logic [3:0] BUS_DR   = 4'd3;
  localparam logic [3:0] BUS_R    = 4'd4;
  localparam logic [3:0] BUS_AC   = 4'd5;
  localparam logic [3:0] BUS_DRAM = 4'd6;
  localparam logic [3:0] BUS_IRAM = 4'd7;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_LDAC  = 4'd1;
  localparam logic [3:0] OP_STAC  = 4'd2;
  localparam logic [3:0] OP_MVACR = 4'd3;
  localparam logic [3:0] OP_MVRAC = 4'd4;
  localparam logic [3:0] OP_ADD   = 4'd5;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_INC   = 4'd7;
  localparam logic [3:0] OP_JUMP  = 4'd8;
  localparam logic [3:0] OP_JMPZ  = 4'd9;
  localparam logic [3:0] OP_HALT  = 4'd15;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_INC  = 3'd3;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_F1     = 3'd1;
  localparam logic [2:0] S_F2     = 3'd2;
  localparam logic [2:0] S_DEC    = 3'd3;
  localparam logic [2:0] S_EA     = 3'd4;
  localparam logic [2:0] S_LD     = 3'd5;
  localparam logic [2:0] S_ST     = 3'd6;
  localparam logic [2:0] S_HALTED = 3'd7;

endpackage

// File: rtl/control_unit_mem_wait_ctr.sv
// Memory-latency wait counter: load, decrement while nonzero, zero detect.
// Used to stretch the instruction-fetch and data-load bus phases.
module mem_wait_ctr (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      count <= 4'd0;
    else if (load)
      count <= load_val;
    else if (dec && count != 4'd0)
      count <= count - 4'd1;
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute microsequencer driving the bus source select and
// datapath strobes; outputs decode from state, wait counter, opcode and z_flag.
module control_unit
  import cu_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic             z_flag,
  output logic [3:0]       bus_sel,
  output logic             ld_ar,
  output logic             ld_pc,
  output logic             inc_pc,
  output logic             ld_ir,
  output logic             ld_dr,
  output logic             ld_r,
  output logic             ld_ac,
  output logic             ld_z,
  output logic [2:0]       alu_op,
  output logic             dram_we,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  logic [2:0] state, nxt;
  logic       ctr_load, ctr_dec, ctr_zero;

  mem_wait_ctr u_wait (
    .clock    (clock),
    .reset    (reset),
    .load     (ctr_load),
    .load_val (4'(MEM_WAIT)),
    .dec      (ctr_dec),
    .zero     (ctr_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      instr_count <= '0;
    end else begin
      state <= nxt;
      if (state == S_DEC)
        instr_count <= instr_count + 1'b1;
    end
  end

  always_comb begin
    nxt      = state;
    ctr_load = 1'b0;
    ctr_dec  = 1'b0;
    bus_sel  = BUS_AR;
    ld_ar    = 1'b0;
    ld_pc    = 1'b0;
    inc_pc   = 1'b0;
    ld_ir    = 1'b0;
    ld_dr    = 1'b0;
    ld_r     = 1'b0;
    ld_ac    = 1'b0;
    ld_z     = 1'b0;
    alu_op   = ALU_PASS;
    dram_we  = 1'b0;
    halted   = 1'b0;
    illegal  = 1'b0;
    busy     = (state != S_IDLE) && (state != S_HALTED);
    case (state)
      S_IDLE: if (start) nxt = S_F1;
      S_F1: begin
        bus_sel  = BUS_PC;
        ld_ar    = 1'b1;
        ctr_load = 1'b1;
        nxt      = S_F2;
      end
      S_F2: begin
        bus_sel = BUS_IRAM;
        if (ctr_zero) begin
          ld_ir  = 1'b1;
          inc_pc = 1'b1;
          nxt    = S_DEC;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      S_DEC: begin
        nxt = S_F1;
        // Single-cycle ops execute here so they cost no extra state.
        case (opcode)
          OP_NOP: ;
          OP_LDAC, OP_STAC: nxt = S_EA;
          OP_MVACR: begin bus_sel = BUS_AC; ld_r = 1'b1; end
          OP_MVRAC: begin bus_sel = BUS_R; ld_ac = 1'b1; end
          OP_ADD, OP_SUB: begin
            bus_sel = BUS_R;
            alu_op  = (opcode == OP_ADD) ? ALU_ADD : ALU_SUB;
            ld_ac   = 1'b1;
            ld_z    = 1'b1;
          end
          OP_INC: begin
            bus_sel = BUS_AC;
            alu_op  = ALU_INC;
            ld_ac   = 1'b1;
            ld_z    = 1'b1;
          end
          OP_JUMP: begin bus_sel = BUS_IR; ld_pc = 1'b1; end
          OP_JMPZ: if (z_flag) begin bus_sel = BUS_IR; ld_pc = 1'b1; end
          OP_HALT: nxt = S_HALTED;
          default: illegal = 1'b1;
        endcase
      end
      S_EA: begin
        bus_sel  = BUS_IR;
        ld_ar    = 1'b1;
        ctr_load = 1'b1;
        nxt      = (opcode == OP_STAC) ? S_ST : S_LD;
      end
      S_LD: begin
        bus_sel = BUS_DRAM;
        if (ctr_zero) begin
          ld_dr  = 1'b1;
          ld_ac  = 1'b1;
          alu_op = ALU_PASS;
          nxt    = S_F1;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      S_ST: begin
        bus_sel = BUS_AC;
        dram_we = 1'b1;
        nxt     = S_F1;
      end
      S_HALTED: halted = 1'b1;
      default: nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction cycle traces from a cycle-index model,
// decode table, random programs, halt, count wrap and async reset mid-load.
module tb_control_unit;

  typedef struct packed {
    logic [3:0] bus;
    logic ld_ar, ld_pc, inc_pc, ld_ir, ld_dr, ld_r, ld_ac, ld_z;
    logic [2:0] alu;
    logic we, busy, halted, illegal;
  } out_t;

  typedef struct {
    logic [3:0] op;
    logic       z;
    logic [3:0] bus;
    logic [7:0] str;
    logic [2:0] alu;
    logic       ill;
  } vec_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // DUT A: MEM_WAIT=1, 4-bit count (exercises wrap)
  logic rst_a = 1'b1, start_a = 1'b0, z_a = 1'b0;
  logic [3:0] op_a = 4'd0;
  logic [3:0] bus_a; logic [2:0] alu_a; logic [3:0] cnt_a;
  logic ar_a, pc_a, ipc_a, ir_a, dr_a, r_a, ac_a, zl_a, we_a, busy_a, halt_a, ill_a;
  out_t oa;
  assign oa = {bus_a, ar_a, pc_a, ipc_a, ir_a, dr_a, r_a, ac_a, zl_a, alu_a, we_a, busy_a, halt_a, ill_a};

  control_unit #(.MEM_WAIT(1), .CNT_W(4)) dut_a (
    .clock(clock), .reset(rst_a), .start(start_a), .opcode(op_a), .z_flag(z_a),
    .bus_sel(bus_a), .ld_ar(ar_a), .ld_pc(pc_a), .inc_pc(ipc_a), .ld_ir(ir_a),
    .ld_dr(dr_a), .ld_r(r_a), .ld_ac(ac_a), .ld_z(zl_a), .alu_op(alu_a),
    .dram_we(we_a), .busy(busy_a), .halted(halt_a), .illegal(ill_a), .instr_count(cnt_a));

  // DUT B: MEM_WAIT=3, 16-bit count (reset during data-load wait)
  logic rst_b = 1'b1, start_b = 1'b0, z_b = 1'b0;
  logic [3:0] op_b = 4'd0;
  logic [3:0] bus_b; logic [2:0] alu_b; logic [15:0] cnt_b;
  logic ar_b, pc_b, ipc_b, ir_b, dr_b, r_b, ac_b, zl_b, we_b, busy_b, halt_b, ill_b;
  out_t ob;
  assign ob = {bus_b, ar_b, pc_b, ipc_b, ir_b, dr_b, r_b, ac_b, zl_b, alu_b, we_b, busy_b, halt_b, ill_b};

  control_unit #(.MEM_WAIT(3), .CNT_W(16)) dut_b (
    .clock(clock), .reset(rst_b), .start(start_b), .opcode(op_b), .z_flag(z_b),
    .bus_sel(bus_b), .ld_ar(ar_b), .ld_pc(pc_b), .inc_pc(ipc_b), .ld_ir(ir_b),
    .ld_dr(dr_b), .ld_r(r_b), .ld_ac(ac_b), .ld_z(zl_b), .alu_op(alu_b),
    .dram_we(we_b), .busy(busy_b), .halted(halt_b), .illegal(ill_b), .instr_count(cnt_b));

  int errs = 0, checks = 0, exp_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int instr_len(input logic [3:0] op, input int w);
    if (op == 4'd1) return 2 * w + 5;
    if (op == 4'd2) return w + 5;
    return w + 3;
  endfunction

  // Expected outputs for cycle k (0 = first fetch cycle) of one instruction.
  function automatic out_t model(input logic [3:0] op, input logic z, input int w, input int k);
    out_t o;
    o = '0;
    o.busy = 1'b1;
    if (k == 0) begin
      o.bus = 4'd1; o.ld_ar = 1'b1;
    end else if (k <= w + 1) begin
      o.bus = 4'd7;
      if (k == w + 1) begin o.ld_ir = 1'b1; o.inc_pc = 1'b1; end
    end else if (k == w + 2) begin
      case (op)
        4'd3: begin o.bus = 4'd5; o.ld_r = 1'b1; end
        4'd4: begin o.bus = 4'd4; o.ld_ac = 1'b1; end
        4'd5, 4'd6: begin o.bus = 4'd4; o.ld_ac = 1'b1; o.ld_z = 1'b1; o.alu = 3'(op - 4'd4); end
        4'd7: begin o.bus = 4'd5; o.ld_ac = 1'b1; o.ld_z = 1'b1; o.alu = 3'd3; end
        4'd8: begin o.bus = 4'd2; o.ld_pc = 1'b1; end
        4'd9: if (z) begin o.bus = 4'd2; o.ld_pc = 1'b1; end
        4'd10, 4'd11, 4'd12, 4'd13, 4'd14: o.illegal = 1'b1;
        default: ;
      endcase
    end else if (k == w + 3) begin
      o.bus = 4'd2; o.ld_ar = 1'b1;
    end else if (op == 4'd2) begin
      o.bus = 4'd5; o.we = 1'b1;
    end else begin
      o.bus = 4'd6;
      if (k == 2 * w + 4) begin o.ld_dr = 1'b1; o.ld_ac = 1'b1; end
    end
    return o;
  endfunction

  // Runs one instruction on DUT A, checking every cycle; start toggles randomly.
  task automatic run_a(input logic [3:0] op, input logic z, output out_t dec_seen);
    dec_seen = '0;
    for (int k = 0; k < instr_len(op, 1); k++) begin
      @(negedge clock);
      chk($sformatf("trace op%0d k%0d", op, k), 32'(oa), 32'(model(op, z, 1, k)));
      if (k == 0) begin
        chk("count", 32'(cnt_a), 32'(exp_cnt % 16));
        op_a = op;
        z_a  = z;
      end
      if (k == 3) dec_seen = oa;
      start_a = 1'($urandom_range(0, 1));
    end
    exp_cnt++;
  endtask

  vec_t tbl[12];
  out_t seen, want, hq;

  initial begin
    tbl[0]  = '{4'd0,  1'b0, 4'd0, 8'b0000_0000, 3'd0, 1'b0};
    tbl[1]  = '{4'd1,  1'b0, 4'd0, 8'b0000_0000, 3'd0, 1'b0};
    tbl[2]  = '{4'd2,  1'b1, 4'd0, 8'b0000_0000, 3'd0, 1'b0};
    tbl[3]  = '{4'd3,  1'b0, 4'd5, 8'b0000_0100, 3'd0, 1'b0};
    tbl[4]  = '{4'd4,  1'b1, 4'd4, 8'b0000_0010, 3'd0, 1'b0};
    tbl[5]  = '{4'd5,  1'b0, 4'd4, 8'b0000_0011, 3'd1, 1'b0};
    tbl[6]  = '{4'd6,  1'b0, 4'd4, 8'b0000_0011, 3'd2, 1'b0};
    tbl[7]  = '{4'd7,  1'b1, 4'd5, 8'b0000_0011, 3'd3, 1'b0};
    tbl[8]  = '{4'd8,  1'b0, 4'd2, 8'b0100_0000, 3'd0, 1'b0};
    tbl[9]  = '{4'd9,  1'b1, 4'd2, 8'b0100_0000, 3'd0, 1'b0};
    tbl[10] = '{4'd9,  1'b0, 4'd0, 8'b0000_0000, 3'd0, 1'b0};
    tbl[11] = '{4'd11, 1'b0, 4'd0, 8'b0000_0000, 3'd0, 1'b1};

    #2;
    chk("reset outs", 32'(oa), 32'h0);
    chk("reset count", 32'(cnt_a), 32'h0);
    @(negedge clock);
    rst_a = 1'b0;
    start_a = 1'b1;

    foreach (tbl[i]) begin
      run_a(tbl[i].op, tbl[i].z, seen);
      want = {tbl[i].bus, tbl[i].str, tbl[i].alu, 1'b0, 1'b1, 1'b0, tbl[i].ill};
      chk($sformatf("decode row %0d", i), 32'(seen), 32'(want));
    end

    for (int n = 0; n < 150; n++)
      run_a(4'($urandom_range(0, 14)), 1'($urandom_range(0, 1)), seen);

    run_a(4'd15, 1'b0, seen);
    hq = '0;
    hq.halted = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      chk("halted hold", 32'(oa), 32'(hq));
      start_a = ~start_a;
    end
    chk("halt count", 32'(cnt_a), 32'(exp_cnt % 16));

    rst_a = 1'b1;
    #1;
    chk("reset from halt", 32'(oa), 32'h0);
    chk("reset count2", 32'(cnt_a), 32'h0);
    @(negedge clock);
    rst_a = 1'b0;
    start_a = 1'b1;
    exp_cnt = 0;
    for (int n = 0; n < 16; n++) run_a(4'd0, 1'b0, seen);
    @(negedge clock);
    chk("wrap to 0", 32'(cnt_a), 32'h0);

    // LDAC on the MEM_WAIT=3 instance, reset while waiting for DRAM data
    @(negedge clock);
    rst_b = 1'b0;
    start_b = 1'b1;
    op_b = 4'd1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clock);
      chk($sformatf("B trace k%0d", k), 32'(ob), 32'(model(4'd1, 1'b0, 3, k)));
    end
    chk("B count pre", 32'(cnt_b), 32'd1);
    rst_b = 1'b1;
    #1;
    chk("B reset outs", 32'(ob), 32'h0);
    chk("B reset count", 32'(cnt_b), 32'h0);
    start_b = 1'b0;
    @(negedge clock);
    rst_b = 1'b0;
    repeat (2) @(negedge clock);
    chk("B idle after reset", 32'(ob), 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
